mem_access_unit: RTL and testbench

- Load/store unit between the EX/MEM pipeline register and the byte-addressed, little-endian 1 KB data memory.
- The memory port only reads and writes whole 32-bit words: read is combinational, write happens on the clock edge.
- This block turns lb/lbu/lh/lhu/lw/sb/sh/sw requests into aligned word accesses, including read-modify-write (RMW) for sub-word stores.
- It sign- or zero-extends load results and holds off the pipeline with a ready/busy handshake.

---
 rtl/mem_access_unit.sv | 217 +++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store unit: turns byte/half/word requests into aligned word accesses with RMW.
// Define MAU_MISALIGN_EXC_EN to raise exc on misaligned requests instead of force-aligning.
module mem_access_unit #(
    parameter int ADDR_W    = 32,
    parameter int MEM_BYTES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              busy,
    output logic              exc,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wd,
    input  logic [31:0]       mem_rd
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STORE,
        RMW_RD,
        RMW_WR,
        EXC
    } state_t;

    localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

    state_t state_q, state_d;

    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [31:0]       rdata_q;
    logic [31:0]       merge_q;
    logic              resp_valid_q;
    logic              resp_set;

    logic              accept;
    logic              req_byte;
    logic              req_half;
    logic [2:0]        req_nbytes;
    logic [ADDR_W:0]   req_end;
    logic              req_oor;
    logic              req_misal;
    logic [ADDR_W-1:0] req_addr_al;

    logic              size_byte;
    logic              size_half;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;
    logic [31:0]       load_ext;
    logic [31:0]       merged;

    assign req_ready = (state_q == IDLE) && !rst;
    assign busy      = !req_ready;
    assign accept    = req_valid && req_ready;

    assign req_byte = (req_size == 2'b00);
    assign req_half = (req_size == 2'b01);

    always_comb begin
        unique case (1'b1)
            req_byte: req_nbytes = 3'd1;
            req_half: req_nbytes = 3'd2;
            default:  req_nbytes = 3'd4;
        endcase
    end

    // Range is judged on the raw address so a straddling access never wraps into range.
    assign req_end = {1'b0, req_addr} + {{(ADDR_W-2){1'b0}}, req_nbytes};
    assign req_oor = req_end > MEM_LIMIT;

`ifdef MAU_MISALIGN_EXC_EN
    assign req_misal   = (req_half && req_addr[0]) ||
                         (!req_byte && !req_half && (req_addr[1:0] != 2'b00));
    assign req_addr_al = req_addr;
`else
    assign req_misal = 1'b0;

    always_comb begin
        req_addr_al = req_addr;
        if (req_half) begin
            req_addr_al[0] = 1'b0;
        end else if (!req_byte) begin
            req_addr_al[1:0] = 2'b00;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        resp_set = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        exc      = 1'b0;
        mem_addr = '0;
        mem_wd   = '0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_oor || req_misal) begin
                        state_d = EXC;
                    end else if (!req_store) begin
                        state_d = LOAD;
                    end else if (!req_byte && !req_half) begin
                        state_d = STORE;
                    end else begin
                        state_d = RMW_RD;
                    end
                end
            end
            LOAD: begin
                MemRead  = 1'b1;
                mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
                resp_set = 1'b1;
                state_d  = IDLE;
            end
            STORE: begin
                MemWrite = 1'b1;
                mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
                mem_wd   = wdata_q;
                resp_set = 1'b1;
                state_d  = IDLE;
            end
            RMW_RD: begin
                MemRead  = 1'b1;
                mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
                state_d  = RMW_WR;
            end
            RMW_WR: begin
                MemWrite = 1'b1;
                mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
                mem_wd   = merged;
                resp_set = 1'b1;
                state_d  = IDLE;
            end
            EXC: begin
                exc     = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign size_byte = (size_q == 2'b00);
    assign size_half = (size_q == 2'b01);

    always_comb begin
        lane_b = mem_rd[{addr_q[1:0], 3'b000} +: 8];
        lane_h = mem_rd[{addr_q[1], 4'b0000} +: 16];
        unique case (1'b1)
            size_byte: load_ext = {{24{lane_b[7] & ~uns_q}}, lane_b};
            size_half: load_ext = {{16{lane_h[15] & ~uns_q}}, lane_h};
            default:   load_ext = mem_rd;
        endcase
    end

    always_comb begin
        merged = merge_q;
        if (size_byte) begin
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q       <= '0;
            wdata_q      <= '0;
            size_q       <= '0;
            uns_q        <= 1'b0;
            rdata_q      <= '0;
            merge_q      <= '0;
            resp_valid_q <= 1'b0;
        end else begin
            resp_valid_q <= resp_set;
            if (accept) begin
                addr_q  <= req_addr_al;
                wdata_q <= req_wdata;
                size_q  <= req_size;
                uns_q   <= req_unsigned;
            end
            if (state_q == LOAD) begin
                rdata_q <= load_ext;
            end
            if (state_q == RMW_RD) begin
                merge_q <= mem_rd;
            end
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a word memory model and a response scoreboard.
// Latency is counted in cycles from the accepting cycle to the cycle showing the response.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        busy;
    logic        exc;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    mem_access_unit dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_store    (req_store),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .busy         (busy),
        .exc          (exc),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .mem_addr     (mem_addr),
        .mem_wd       (mem_wd),
        .mem_rd       (mem_rd)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:255];
    assign mem_rd = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (MemWrite) mem[mem_addr[9:2]] <= mem_wd;
    end

    typedef struct {
        bit          ex;
        bit          ld;
        logic [31:0] rd;
        int          lat;
        time         t0;
    } exp_t;

    exp_t sb[$];

    int tests = 0;
    int fails = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int both_cnt = 0;
    time last_acc;
    logic [31:0] last_load = 32'h0;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Monitor: count memory strobes and check each response against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (MemRead && MemWrite) both_cnt++;
            if (MemWrite) wr_cnt++;
            if (MemRead) rd_cnt++;
            if (resp_valid || exc) begin
                if (sb.size() == 0) begin
                    chk("unexpected_resp", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    chk("exc", {31'b0, exc}, {31'b0, e.ex});
                    chk("resp_valid", {31'b0, resp_valid}, {31'b0, !e.ex});
                    if (e.ld && !e.ex) chk("rdata", resp_rdata, e.rd);
                    chk("latency", 32'(($time - e.t0 + 5) / 10), 32'(e.lat));
                end
            end
        end
    end

    task automatic send(input bit st, input logic [1:0] sz, input bit uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        input bit ex, input logic [31:0] rd, input int lat);
        int n;
        exp_t e;
        n = 0;
        @(negedge clk);
        req_valid    = 1'b1;
        req_store    = st;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        last_acc = $time;
        e.ex  = ex;
        e.ld  = !st;
        e.rd  = rd;
        e.lat = lat;
        e.t0  = $time;
        sb.push_back(e);
        if (!st && !ex) last_load = rd;
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge clk);
        req_valid = 1'b0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(sb.size()), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int w0;
        int r0;
        time t_first;
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_store    = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_exc", {31'b0, exc}, 32'd0);
        chk("rst_memctl", {30'b0, MemRead, MemWrite}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_rdata", resp_rdata, 32'h0);

        w0 = wr_cnt;
        send(1'b1, SZ_W, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 2);
        drain();
        chk("sw_write_cycles", 32'(wr_cnt - w0), 32'd1);
        send(1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 2);
        drain();

        w0 = wr_cnt;
        r0 = rd_cnt;
        send(1'b1, SZ_B, 1'b0, 32'h11, 32'hFFFFFF55, 1'b0, 32'h0, 3);
        drain();
        chk("sb_mem_word", mem[4], 32'hDEAD55EF);
        chk("sb_rmw_strobes", 32'((wr_cnt - w0) * 16 + (rd_cnt - r0)), 32'h11);
        chk("sb_keeps_rdata", resp_rdata, last_load);
        send(1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD55EF, 2);
        drain();

        send(1'b0, SZ_B, 1'b0, 32'h13, 32'h0, 1'b0, 32'hFFFFFFDE, 2);
        send(1'b0, SZ_B, 1'b1, 32'h13, 32'h0, 1'b0, 32'h000000DE, 2);
        send(1'b0, SZ_H, 1'b0, 32'h12, 32'h0, 1'b0, 32'hFFFFDEAD, 2);
        send(1'b0, SZ_H, 1'b1, 32'h12, 32'h0, 1'b0, 32'h0000DEAD, 2);
        send(1'b0, SZ_B, 1'b0, 32'h11, 32'h0, 1'b0, 32'h00000055, 2);
        send(1'b0, SZ_H, 1'b0, 32'h10, 32'h0, 1'b0, 32'h000055EF, 2);
        drain();

        w0 = wr_cnt;
        r0 = rd_cnt;
`ifdef MAU_MISALIGN_EXC_EN
        send(1'b0, SZ_W, 1'b0, 32'h12, 32'h0, 1'b1, 32'h0, 1);
        drain();
        chk("misal_no_access", 32'((wr_cnt - w0) + (rd_cnt - r0)), 32'd0);
`else
        send(1'b0, SZ_W, 1'b0, 32'h12, 32'h0, 1'b0, 32'hDEAD55EF, 2);
        drain();
        chk("misal_one_read", 32'((wr_cnt - w0) + (rd_cnt - r0)), 32'd1);
`endif

        w0 = wr_cnt;
        r0 = rd_cnt;
        send(1'b1, SZ_W, 1'b0, 32'h3FE, 32'hCAFEF00D, 1'b1, 32'h0, 1);
        drain();
        chk("oor_no_access", 32'((wr_cnt - w0) + (rd_cnt - r0)), 32'd0);
        chk("oor_mem_ff", mem[255], 32'hX);
        chk("oor_keeps_rdata", resp_rdata, last_load);

        send(1'b1, SZ_W, 1'b0, 32'h20, 32'h12345678, 1'b0, 32'h0, 2);
        t_first = last_acc;
        send(1'b0, SZ_W, 1'b0, 32'h20, 32'h0, 1'b0, 32'h12345678, 2);
        chk("b2b_accept_gap", 32'(last_acc - t_first), 32'd20);
        drain();

        w0 = wr_cnt;
        send(1'b1, SZ_H, 1'b0, 32'h20, 32'h0000AAAA, 1'b0, 32'h0, 3);
        #2;
        rst = 1'b1;
        req_valid = 1'b0;
        #1;
        chk("abort_memwrite", {31'b0, MemWrite}, 32'd0);
        chk("abort_memread", {31'b0, MemRead}, 32'd0);
        chk("abort_ready", {31'b0, req_ready}, 32'd0);
        chk("abort_busy", {31'b0, busy}, 32'd1);
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_no_write", 32'(wr_cnt - w0), 32'd0);
        chk("abort_mem_word", mem[8], 32'h12345678);
        send(1'b0, SZ_W, 1'b0, 32'h20, 32'h0, 1'b0, 32'h12345678, 2);
        drain();

        send(1'b1, SZ_H, 1'b0, 32'h22, 32'hCAFEBEEF, 1'b0, 32'h0, 3);
        drain();
        chk("sh_mem_word", mem[8], 32'hBEEF5678);
        send(1'b0, SZ_H, 1'b0, 32'h22, 32'h0, 1'b0, 32'hFFFFBEEF, 2);
        send(1'b0, SZ_B, 1'b1, 32'h21, 32'h0, 1'b0, 32'h00000056, 2);
        drain();

        chk("rd_wr_exclusive", 32'(both_cnt), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
